// File: rtl/ir_decoder.sv
// ir_decoder -- NEC-format infrared receive decoder.
//
// Measures mark/space durations of a demodulated IR receiver output against
// NEC timing windows and reassembles 32-bit frames in the same bit layout
// that ir_encoder consumes (first received bit lands in cmd[0]). Completed
// frames are offered on a valid/ready handshake.
//
// Optional feature: define IR_DECODER_GLITCH_FILTER_EN to insert a glitch
// filter after the synchronizer. The filter passes a level only after it has
// been stable for GLITCH_CYCLES clocks. Without the macro, the synchronized
// level feeds edge detection directly.
//
// Parameters:
//   TICK_CYCLES   clk cycles per measurement tick (10 ticks = one NEC unit)
//   INVERT        1: ir_input low means carrier present (mark)
//   GLITCH_CYCLES stability requirement of the optional glitch filter
//
// Ports:
//   clk      sole clock
//   rst      asynchronous active-low reset
//   ir_input raw demodulated IR level, asynchronous to clk
//   cmd      last accepted frame, first received bit in cmd[0]
//   valid    cmd holds an unconsumed frame
//   ready    consumer accepts cmd when valid && ready
//   rpt      one-cycle pulse on a valid NEC repeat frame ("repeat" is a
//            reserved word, hence the short name)
//   err      one-cycle pulse on any timing or check failure
//   overrun  one-cycle pulse when a good frame is dropped while valid is held
//   busy     FSM is not in IDLE
module ir_decoder #(
  parameter int TICK_CYCLES   = 1406,
  parameter int INVERT        = 1,
  parameter int GLITCH_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_input,
  output logic [31:0] cmd,
  output logic        valid,
  input  logic        ready,
  output logic        rpt,
  output logic        err,
  output logic        overrun,
  output logic        busy
);

  localparam logic INV = (INVERT != 0);
  localparam int   PW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  if (TICK_CYCLES < 1 || GLITCH_CYCLES < 1) begin : g_param_check
    $error("ir_decoder: TICK_CYCLES and GLITCH_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_RPT_MARK
  } state_t;

  function automatic logic in_win(input logic [7:0] c, input logic [7:0] lo,
                                  input logic [7:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          level, mark, edge_det;
  logic          mark_q, mark_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [31:0]   shift_q, shift_d, cmd_q, cmd_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic          valid_q, valid_d, good_q, good_d;
  logic          err_q, err_d, rpt_q, rpt_d, ovr_q, ovr_d;

`ifdef IR_DECODER_GLITCH_FILTER_EN
  localparam int FW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Count consecutive clocks on which the synchronized level disagrees with
  // the filtered one; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FW'(GLITCH_CYCLES - 1)) filt_d = sync2_q;
      else                                  fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= INV;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign mark     = level ^ INV;
  assign edge_det = mark ^ mark_q;

  // Input path and duration measurement: both counters restart on every
  // edge, so cnt_q is the number of whole ticks spent in the current level.
  always_comb begin
    sync1_d = ir_input;
    sync2_d = sync1_q;
    mark_d  = mark;
    presc_d = presc_q + 1'b1;
    cnt_d   = cnt_q;
    if (edge_det) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (presc_q == PW'(TICK_CYCLES - 1)) begin
      presc_d = '0;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  // Frame FSM: each level is judged at the edge that ends it.
  always_comb begin
    logic fail;
    logic bit_val;
    fail      = 1'b0;
    bit_val   = 1'b0;
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cmd_d     = cmd_q;
    valid_d   = valid_q;
    good_d    = good_q;
    err_d     = 1'b0;
    rpt_d     = 1'b0;
    ovr_d     = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: if (edge_det && mark) state_d = S_LEAD_MARK;
      S_LEAD_MARK: if (edge_det) begin
        if (in_win(cnt_q, 8'd128, 8'd192)) state_d = S_LEAD_SPACE;
        else                               fail    = 1'b1;
      end
      S_LEAD_SPACE: if (edge_det) begin
        if (in_win(cnt_q, 8'd64, 8'd96)) begin
          state_d   = S_BIT_MARK;
          bit_idx_d = 5'd0;
        end else if (in_win(cnt_q, 8'd32, 8'd48)) begin
          state_d = S_RPT_MARK;
        end else begin
          fail = 1'b1;
        end
      end
      S_BIT_MARK: if (edge_det) begin
        if (in_win(cnt_q, 8'd6, 8'd14)) state_d = S_BIT_SPACE;
        else                            fail    = 1'b1;
      end
      S_BIT_SPACE: if (edge_det) begin
        if (in_win(cnt_q, 8'd6, 8'd14))       bit_val = 1'b0;
        else if (in_win(cnt_q, 8'd22, 8'd38)) bit_val = 1'b1;
        else                                  fail    = 1'b1;
        if (!fail) begin
          shift_d   = {bit_val, shift_q[31:1]};
          bit_idx_d = bit_idx_q + 5'd1;
          state_d   = (bit_idx_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
        end
      end
      S_STOP_MARK: if (edge_det) begin
        if (in_win(cnt_q, 8'd6, 8'd14)) begin
          state_d = S_IDLE;
          if (shift_q[31:24] == ~shift_q[23:16]) begin
            good_d = 1'b1;
            // Completion together with valid && ready is a handover, not a drop.
            if (!valid_q || ready) begin
              cmd_d   = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          fail = 1'b1;
        end
      end
      S_RPT_MARK: if (edge_det) begin
        if (in_win(cnt_q, 8'd6, 8'd14)) begin
          state_d = S_IDLE;
          if (good_q) rpt_d = 1'b1;
          else        err_d = 1'b1;
        end else begin
          fail = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout; a mark still held here re-arms only on its next rising edge.
    if (state_q != S_IDLE && !edge_det && cnt_q >= 8'd200) fail = 1'b1;

    if (fail) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
      shift_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= INV;
      sync2_q   <= INV;
      mark_q    <= 1'b0;
      presc_q   <= '0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      cmd_q     <= '0;
      valid_q   <= 1'b0;
      good_q    <= 1'b0;
      err_q     <= 1'b0;
      rpt_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      mark_q    <= mark_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      cmd_q     <= cmd_d;
      valid_q   <= valid_d;
      good_q    <= good_d;
      err_q     <= err_d;
      rpt_q     <= rpt_d;
      ovr_q     <= ovr_d;
    end
  end

  assign cmd     = cmd_q;
  assign valid   = valid_q;
  assign rpt     = rpt_q;
  assign err     = err_q;
  assign overrun = ovr_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_decoder.sv
// tb_ir_decoder -- directed bench for ir_decoder.
// Runs with TICK_CYCLES=2 so one NEC unit (10 ticks) is 20 clocks at 25 MHz.
// A level lasting n clocks measures floor((n-1)/2) ticks.
module tb_ir_decoder;

  localparam int TICK = 2;
  localparam int U    = 20;
`ifdef IR_DECODER_GLITCH_FILTER_EN
  localparam int LAT = 3 + 16;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ir_input = 1'b1;
  logic        ready = 1'b0;
  logic [31:0] cmd;
  logic        valid, rpt, err, overrun, busy;

  int checks = 0, failures = 0;
  int err_cnt = 0, rpt_cnt = 0, ovr_cnt = 0, multi_cnt = 0, wide_cnt = 0;
  logic err_prev = 1'b0, rpt_prev = 1'b0, ovr_prev = 1'b0;

  ir_decoder #(.TICK_CYCLES(TICK), .INVERT(1), .GLITCH_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .ir_input(ir_input), .cmd(cmd), .valid(valid),
    .ready(ready), .rpt(rpt), .err(err), .overrun(overrun), .busy(busy)
  );

  always #20 clk = ~clk;

  // Pulse bookkeeping on the inactive edge.
  always @(negedge clk) begin
    if (err)     err_cnt++;
    if (rpt)     rpt_cnt++;
    if (overrun) ovr_cnt++;
    if ((int'(err) + int'(rpt) + int'(overrun)) > 1) multi_cnt++;
    if ((err && err_prev) || (rpt && rpt_prev) || (overrun && ovr_prev)) wide_cnt++;
    err_prev = err;
    rpt_prev = rpt;
    ovr_prev = overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic lvl, input int n);
    ir_input = lvl;
    wait_cyc(n);
  endtask

  // Leader plus the first nbits data bits (ir low = mark).
  task automatic send_bits(input logic [31:0] v, input int nbits);
    seg(1'b0, 16 * U);
    seg(1'b1, 8 * U);
    for (int i = 0; i < nbits; i++) begin
      seg(1'b0, U);
      seg(1'b1, v[i] ? 3 * U : U);
    end
  endtask

  // Returns right after the raw transition that ends the stop mark.
  task automatic send_frame(input logic [31:0] v);
    send_bits(v, 32);
    seg(1'b0, U);
    ir_input = 1'b1;
  endtask

  task automatic send_repeat();
    seg(1'b0, 16 * U);
    seg(1'b1, 4 * U);
    seg(1'b0, U);
    ir_input = 1'b1;
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
  endtask

  initial begin
    wait_cyc(4);
    chk("reset_cmd", cmd, 32'h0);
    chk("reset_valid", {31'b0, valid}, 32'h0);
    chk("reset_flags", {28'b0, busy, overrun, err, rpt}, 32'h0);
    rst = 1'b1;
    wait_cyc(4);

    // Repeat with no good frame since reset -> err
    send_repeat();
    wait_cyc(LAT + 2);
    chk("rpt_no_frame_err", err_cnt, 1);
    chk("rpt_no_frame_rpt", rpt_cnt, 0);

    // Nominal frame, latency and handshake
    send_frame(32'h9D620707);
    wait_cyc(LAT - 1);
    chk("lat_before", {31'b0, valid}, 0);
    wait_cyc(1);
    chk("lat_valid", {31'b0, valid}, 1);
    chk("frame1_cmd", cmd, 32'h9D620707);
    wait_cyc(50);
    chk("valid_hold", {31'b0, valid}, 1);
    chk("busy_idle", {31'b0, busy}, 0);
    pulse_ready();
    chk("valid_cleared", {31'b0, valid}, 0);
    chk("cmd_retained", cmd, 32'h9D620707);

    // Repeat after a good frame
    send_repeat();
    wait_cyc(LAT + 2);
    chk("rpt_count", rpt_cnt, 1);
    chk("rpt_no_err", err_cnt, 1);
    chk("rpt_cmd", cmd, 32'h9D620707);
    chk("rpt_valid", {31'b0, valid}, 0);

    // Check-byte mismatch
    send_frame(32'h9C620707);
    wait_cyc(LAT + 2);
    chk("badchk_err", err_cnt, 2);
    chk("badchk_valid", {31'b0, valid}, 0);
    chk("badchk_cmd", cmd, 32'h9D620707);

    // 5 ms leader mark (88 ticks) is out of window
    seg(1'b0, 178);
    chk("short_lead_busy", {31'b0, busy}, 1);
    ir_input = 1'b1;
    wait_cyc(LAT + 2);
    chk("short_lead_err", err_cnt, 3);
    chk("short_lead_idle", {31'b0, busy}, 0);

    // Overrun: second good frame while first is unconsumed
    send_frame(32'h9D620707);
    wait_cyc(LAT + 2);
    chk("ovr_first_valid", {31'b0, valid}, 1);
    send_frame(32'h9F600707);
    wait_cyc(LAT + 2);
    chk("ovr_count", ovr_cnt, 1);
    chk("ovr_cmd_kept", cmd, 32'h9D620707);
    chk("ovr_valid", {31'b0, valid}, 1);
    chk("ovr_no_err", err_cnt, 3);

    // Completion in the same cycle as valid && ready -> handover, no overrun
    send_frame(32'h9F600707);
    wait_cyc(LAT - 1);
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    chk("handover_cmd", cmd, 32'h9F600707);
    chk("handover_valid", {31'b0, valid}, 1);
    chk("handover_no_ovr", ovr_cnt, 1);
    pulse_ready();
    chk("handover_cleared", {31'b0, valid}, 0);

    // Timeout with mark still held; release must not re-arm
    seg(1'b0, 440);
    chk("timeout_err", err_cnt, 4);
    chk("timeout_idle", {31'b0, busy}, 0);
    seg(1'b1, 40);
    chk("timeout_release", err_cnt, 4);
    chk("timeout_release_idle", {31'b0, busy}, 0);

    // Reset during bit 12 mark
    send_bits(32'h9D620707, 12);
    seg(1'b0, 10);
    chk("mid_busy", {31'b0, busy}, 1);
    rst = 1'b0;
    ir_input = 1'b1;
    wait_cyc(3);
    chk("mid_reset_cmd", cmd, 32'h0);
    chk("mid_reset_flags", {28'b0, busy, overrun, err, rpt}, 32'h0);
    rst = 1'b1;
    wait_cyc(10);
    send_frame(32'h9D620707);
    wait_cyc(LAT + 2);
    chk("post_reset_cmd", cmd, 32'h9D620707);
    chk("post_reset_valid", {31'b0, valid}, 1);
    chk("post_reset_no_err", err_cnt, 4);
    pulse_ready();

    // 200 ns (5 clk) low glitch early in the space of bit 3 (a 0 bit)
    seg(1'b0, 16 * U);
    seg(1'b1, 8 * U);
    for (int i = 0; i < 32; i++) begin
      seg(1'b0, U);
      if (i == 3) begin
        seg(1'b1, 4);
        seg(1'b0, 5);
        seg(1'b1, 11);
      end else begin
        seg(1'b1, ((32'h9F600707 >> i) & 1) != 0 ? 3 * U : U);
      end
    end
    seg(1'b0, U);
    ir_input = 1'b1;
    wait_cyc(LAT + 2);
`ifdef IR_DECODER_GLITCH_FILTER_EN
    chk("glitch_cmd", cmd, 32'h9F600707);
    chk("glitch_valid", {31'b0, valid}, 1);
    chk("glitch_no_err", err_cnt, 4);
`else
    chk("glitch_err", {31'b0, (err_cnt > 4)}, 1);
    chk("glitch_valid", {31'b0, valid}, 0);
    chk("glitch_cmd", cmd, 32'h9D620707);
`endif

    chk("pulses_exclusive", multi_cnt, 0);
    chk("pulses_one_cycle", wide_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
